// File: rtl/reg_xfer.sv
// Register-to-register transfer sequencer driving an external register file with a registered read port.
// Optional feature: define REG_XFER_INCDEC_EN to give op 01/10 increment/decrement behaviour.
package common_types;
   typedef logic [7:0] data_t;
   typedef logic [2:0] regf_t;
   typedef enum logic {Read = 1'b0, Write = 1'b1} rw_t;
endpackage

module reg_xfer
   import common_types::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  regf_t       src,
   input  regf_t       dst,
   input  data_t       imm,
   output logic        busy,
   output logic        done,
   output logic        flag_n,
   output logic        flag_z,
   output rw_t         rf_rw,
   output regf_t       rf_sel,
   output data_t       rf_wdata,
   input  data_t       rf_rdata
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CAP  = 3'd2,
      WR   = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t      state, state_nxt;
   logic [1:0]  op_q, op_nxt;
   regf_t       src_q, src_nxt;
   regf_t       dst_q, dst_nxt;
   data_t       imm_q, imm_nxt;
   data_t       result, result_nxt;
   logic        flag_n_nxt, flag_z_nxt;
   logic        busy_nxt, done_nxt;
   rw_t         rf_rw_nxt;
   regf_t       rf_sel_nxt;

   function automatic data_t xfer_f(input logic [1:0] f_op, input data_t rdata, input data_t f_imm);
      data_t r;
      case (f_op)
`ifdef REG_XFER_INCDEC_EN
         2'b01:   r = rdata + 8'd1;
         2'b10:   r = rdata - 8'd1;
`endif
         2'b11:   r = f_imm;
         default: r = rdata;
      endcase
      return r;
   endfunction

   // Next-state logic; outputs are decoded from the next state so they leave the flops directly.
   always_comb begin
      state_nxt  = state;
      op_nxt     = op_q;
      src_nxt    = src_q;
      dst_nxt    = dst_q;
      imm_nxt    = imm_q;
      result_nxt = result;
      flag_n_nxt = flag_n;
      flag_z_nxt = flag_z;

      case (state)
         IDLE: begin
            if (start) begin
               op_nxt  = op;
               src_nxt = src;
               dst_nxt = dst;
               imm_nxt = imm;
               if (op == 2'b11) begin
                  state_nxt  = WR;
                  result_nxt = imm;
               end else begin
                  state_nxt  = RD;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         RD:   state_nxt = CAP;
         CAP: begin
            result_nxt = xfer_f(op_q, rf_rdata, imm_q);
            state_nxt  = WR;
         end
         WR: begin
            flag_n_nxt = result[7];
            flag_z_nxt = (result == 8'h00);
            state_nxt  = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      busy_nxt   = 1'b1;
      done_nxt   = 1'b0;
      rf_rw_nxt  = Read;
      rf_sel_nxt = 3'd0;
      case (state_nxt)
         IDLE:    busy_nxt = 1'b0;
         RD:      rf_sel_nxt = src_nxt;
         CAP:     rf_sel_nxt = src_nxt;
         WR: begin
            rf_rw_nxt  = Write;
            rf_sel_nxt = dst_nxt;
         end
         DONE:    done_nxt = 1'b1;
         default: busy_nxt = 1'b0;
      endcase
   end

   // State, operand and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state  <= IDLE;
         op_q   <= 2'd0;
         src_q  <= 3'd0;
         dst_q  <= 3'd0;
         imm_q  <= 8'd0;
         result <= 8'd0;
         flag_n <= 1'b0;
         flag_z <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         rf_rw  <= Read;
         rf_sel <= 3'd0;
      end else begin
         state  <= state_nxt;
         op_q   <= op_nxt;
         src_q  <= src_nxt;
         dst_q  <= dst_nxt;
         imm_q  <= imm_nxt;
         result <= result_nxt;
         flag_n <= flag_n_nxt;
         flag_z <= flag_z_nxt;
         busy   <= busy_nxt;
         done   <= done_nxt;
         rf_rw  <= rf_rw_nxt;
         rf_sel <= rf_sel_nxt;
      end
   end

   // The result register only changes on the edge entering WR, so it doubles as held write data.
   assign rf_wdata = result;

endmodule

// File: doc/reg_xfer.md
REG_XFER -- requirements
Module: reg_xfer

Interface
REQ-001 Parameters: none; widths SHALL be fixed by common_types: data_t 8 bit, regf_t 3 bit, rw_t {Read, Write}.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request; accepted only when state is IDLE.
REQ-005 op  input  2  00 TRANSFER, 01 INC, 10 DEC, 11 LOAD (immediate).
REQ-006 src  input  3  source register select (regf_t).
REQ-007 dst  input  3  destination register select (regf_t).
REQ-008 imm  input  8  immediate value for LOAD.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 flag_n  output  1  result bit 7 of last completed op.
REQ-012 flag_z  output  1  high when result of last completed op == 0x00.
REQ-013 rf_rw  output  rw_t  register-file command.
REQ-014 rf_sel  output  3  register-file select.
REQ-015 rf_wdata  output  8  register-file write data.
REQ-016 rf_rdata  input  8  register-file read data, registered: valid the cycle after Read+sel sampled.

Function
REQ-017 States SHALL be IDLE, RD, CAP, WR, DONE.
REQ-018 IDLE: start=1 at an edge latches op/src/dst/imm; next state RD for op 00/01/10, WR for op 11.
REQ-019 RD: drive rf_rw=Read, rf_sel=src_q; next CAP unconditionally.
REQ-020 CAP: at the edge leaving CAP, result = f(rf_rdata) latched; next WR.
REQ-021 f: TRANSFER = rf_rdata; INC = rf_rdata+1 mod 256; DEC = rf_rdata-1 mod 256; LOAD = imm_q.
REQ-022 WR: drive rf_rw=Write, rf_sel=dst_q, rf_wdata=result; at edge leaving WR, flag_n/flag_z update from result; next DONE.
REQ-023 DONE: done=1 for exactly this one cycle, rf_rw=Read; next IDLE.
REQ-024 IDLE/DONE/CAP outputs: rf_rw=Read; rf_sel=0 in IDLE/DONE, src_q in CAP; rf_wdata holds last value.
REQ-025 Latency: start edge E0 -> done high in cycle after E3 (TRANSFER/INC/DEC), after E1 (LOAD); one Write cycle per op.
REQ-026 start while busy SHALL be ignored and not queued; operand input changes after acceptance SHALL have no effect.
REQ-027 start asserted in DONE cycle ignored; next request accepted only from IDLE.
REQ-028 src==dst SHALL be legal (in-place INC/DEC).
REQ-029 Wrap: INC 0xFF -> 0x00 (Z=1,N=0); DEC 0x00 -> 0xFF (Z=0,N=1).
REQ-030 Flags SHALL change only on WR exit; unchanged otherwise.

Reset
REQ-031 reset_n=0 at an edge SHALL force IDLE, busy=0, done=0, flag_n=0, flag_z=0, rf_rw=Read, rf_sel=0, rf_wdata=0, latched operands 0.
REQ-032 Reset mid-operation (including WR) SHALL abort; rf_rw=Read from the cycle after the reset edge; no done pulse; reset takes priority over start.

Configuration
REQ-033 Macro REG_XFER_INCDEC_EN defined: op 01/10 perform INC/DEC per REQ-021.
REQ-034 Macro undefined: op 01/10 SHALL behave exactly as TRANSFER (no adder logic), same latency.

Verification
REQ-035 Preload R1=0x80; start op=00 src=1 dst=2 -> RD/CAP/WR/DONE sequence, R2=0x80, flag_n=1, flag_z=0, done on 4th cycle after start edge.
REQ-036 (INCDEC_EN) R3=0xFF; op=01 src=dst=3 -> R3=0x00, flag_z=1, flag_n=0; R3=0x00, op=10 -> R3=0xFF, flag_n=1.
REQ-037 op=11 imm=0x00 dst=5 -> single Write cycle, R5=0x00, flag_z=1, done on 2nd cycle after start edge; no Read of src issued.
REQ-038 start held high continuously for 10 cycles, op=00 -> exactly 2 completions (done at cycles 4 and 9), no overlapping Write.
REQ-039 reset_n=0 during WR cycle -> next cycle IDLE, rf_rw=Read, flags 0, done never asserted, subsequent op completes normally.
REQ-040 Macro undefined: R4=0x7F, op=01 src=4 dst=6 -> R6=0x7F, flag_n=0, flag_z=0.
